// File: rtl/uart_port_scheduler_pkg.sv
// uart_ctrl_pkg: FSM state types and UART timing constants for uart_port_scheduler.
package uart_ctrl_pkg;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_e;
  typedef enum logic {R_IDLE, R_CLEAR} rx_state_e;
  localparam int UART_CLK_RATIO = 20;
  localparam int FRAME_BITS = 11;
  localparam int TRANS_HOLD_DEF = 2 * UART_CLK_RATIO;
  localparam int TX_FRAME_CYCLES_DEF = FRAME_BITS * UART_CLK_RATIO + UART_CLK_RATIO;
endpackage

// File: rtl/uart_port_scheduler_if.sv
// uart_port_scheduler_if: requester, UART wrapper and RX consumer signals of the scheduler.
interface uart_port_scheduler_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 8);
  logic [NUM_REQ-1:0] req, gnt;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic tx_busy, uart_trans, uart_rx_flag, uart_parity_err, uart_clear_int;
  logic [DATA_W-1:0] uart_data, uart_rx_data, rx_data;
  logic rx_perr, rx_valid, rx_ready, rx_overrun, ovr_clr;
  modport master(output req, req_data, uart_rx_flag, uart_rx_data, uart_parity_err, rx_ready, ovr_clr,
                 input gnt, tx_busy, uart_data, uart_trans, uart_clear_int, rx_data, rx_perr, rx_valid, rx_overrun);
  modport slave(input req, req_data, uart_rx_flag, uart_rx_data, uart_parity_err, rx_ready, ovr_clr,
                output gnt, tx_busy, uart_data, uart_trans, uart_clear_int, rx_data, rx_perr, rx_valid, rx_overrun);
endinterface

// File: rtl/uart_port_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick searching upward from ptr with wrap.
module rr_arbiter #(parameter int NUM_REQ = 4, localparam int IW = $clog2(NUM_REQ)) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_port_scheduler.sv
// uart_port_scheduler: paced RR TX arbitration and RX interrupt service; `UART_PARITY_DROP_EN discards parity-error bytes.
module uart_port_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int TRANS_HOLD = TRANS_HOLD_DEF,
  parameter int TX_FRAME_CYCLES = TX_FRAME_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  uart_port_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TX_FRAME_CYCLES);
  tx_state_e tx_state;
  rx_state_e rx_state;
  logic [IW-1:0] ptr, idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic any, flag_s1, flag_s2, drop, perr_in, take, cap, ovf;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sel;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req), .ptr(ptr), .gnt(arb_gnt), .idx(idx), .any(any));
  // gnt is gated by reset so it drops asynchronously with the rest of the block
  assign bus.gnt = (tx_state == T_IDLE && reset) ? arb_gnt : '0;
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (arb_gnt[k]) sel = bus.req_data[k*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_state <= T_IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.uart_data <= '0;
      bus.uart_trans <= 1'b0;
      bus.tx_busy <= 1'b0;
    end else case (tx_state)
      T_IDLE: if (any) begin
        bus.uart_data <= sel;
        ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        cnt <= '0;
        bus.uart_trans <= 1'b1;
        bus.tx_busy <= 1'b1;
        tx_state <= T_SEND;
      end
      T_SEND: begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(TRANS_HOLD - 1)) begin
          bus.uart_trans <= 1'b0;
          tx_state <= T_WAIT;
        end
      end
      T_WAIT: begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(TX_FRAME_CYCLES - 1)) begin
          bus.tx_busy <= 1'b0;
          tx_state <= T_IDLE;
        end
      end
      default: tx_state <= T_IDLE;
    endcase
`ifdef UART_PARITY_DROP_EN
  assign drop = bus.uart_parity_err;
  assign perr_in = 1'b0;
`else
  assign drop = 1'b0;
  assign perr_in = bus.uart_parity_err;
`endif
  assign take = rx_state == R_IDLE && flag_s2 && !drop;
  assign cap = take && (!bus.rx_valid || bus.rx_ready);
  assign ovf = take && !cap;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      flag_s1 <= 1'b0;
      flag_s2 <= 1'b0;
      rx_state <= R_IDLE;
      bus.uart_clear_int <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_perr <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else begin
      flag_s1 <= bus.uart_rx_flag;
      flag_s2 <= flag_s1;
      if (cap) begin
        bus.rx_data <= bus.uart_rx_data;
        bus.rx_perr <= perr_in;
      end
      bus.rx_valid <= cap || (bus.rx_valid && !bus.rx_ready);
      bus.rx_overrun <= ovf || (bus.rx_overrun && !bus.ovr_clr);
      case (rx_state)
        R_IDLE: if (flag_s2) begin
          rx_state <= R_CLEAR;
          bus.uart_clear_int <= 1'b1;
        end
        R_CLEAR: if (!flag_s2) begin
          rx_state <= R_IDLE;
          bus.uart_clear_int <= 1'b0;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
endmodule
